execute_mem_reg: RTL and testbench

- Pipeline boundary between the Execute stage (ALU result plus NZVC flags) and the Memory stage of the vectorized CPU.
- Registers the ALU result, destination and memory/writeback control bits behind a 2-entry skid buffer with a valid/ready handshake.
- Owns the architectural NZVC condition-flag register.
- Provides a flush for branch redirects.

---
 rtl/exe_pkg.sv | 25 ++
 rtl/execute_flags_reg.sv | 14 +
 rtl/execute_mem_reg.sv | 71 +++++++
 tb/tb_execute_mem_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: shared types and ALU encodings for the execute/memory boundary.
package exe_pkg;
  localparam int EXE_WIDTH = 48;
  localparam int EXE_RADDR = 4;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011;
  localparam logic [2:0] XOR = 3'b100, SHL = 3'b101, PASSA = 3'b110, PASSB = 3'b111;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } exe_ctrl_t;
  typedef struct packed {
    logic [EXE_WIDTH-1:0] result;
    logic [EXE_WIDTH-1:0] store_data;
    logic [EXE_RADDR-1:0] rd;
    exe_ctrl_t            ctrl;
    logic                 valid;
  } exe_entry_t;
endpackage

// File: rtl/execute_flags_reg.sv
// execute_flags_reg: architectural NZVC register with load enable.
module execute_flags_reg
  import exe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  flags_t d,
  output flags_t q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/execute_mem_reg.sv
// execute_mem_reg: execute->memory pipeline register with 2-entry skid buffer and NZVC flags.
module execute_mem_reg
  import exe_pkg::*;
#(
  parameter int WIDTH = EXE_WIDTH,
  parameter int RADDR = EXE_RADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic [WIDTH-1:0] store_data,
  input  logic [RADDR-1:0] rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [RADDR-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [3:0]       flags
);
  exe_entry_t main_q, skid_q, in_e, view;
  flags_t flag_q;
  logic accept, drain;
  assign in_e = {alu_out, store_data, rd, reg_write, mem_read, mem_write, 1'b1};
  assign in_ready = ~skid_q.valid;
  assign accept = in_valid & in_ready & ~flush;
  assign drain = ~main_q.valid | out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else if (drain) begin
      main_q <= skid_q.valid ? skid_q : accept ? in_e : '0;
      skid_q.valid <= 1'b0;
    end else if (accept) begin
      skid_q <= in_e;
    end
  // Stale payload left behind by a flush must never leak onto the ports.
  assign view = main_q.valid ? main_q : '0;
  assign out_valid = view.valid;
  assign out_result = view.result;
  assign out_store_data = view.store_data;
  assign out_rd = view.rd;
  assign out_reg_write = view.ctrl.reg_write;
  assign out_mem_read = view.ctrl.mem_read;
  assign out_mem_write = view.ctrl.mem_write;
  execute_flags_reg u_flags (
    .clk(clk),
    .rst(rst),
    .load(accept & set_flags),
    .d({alu_n, alu_z, alu_v, alu_c}),
    .q(flag_q)
  );
  assign flags = flag_q;
endmodule

// File: tb/tb_execute_mem_reg.sv
// tb_execute_mem_reg: directed vectors checked against a FIFO-level model every cycle.
module tb_execute_mem_reg;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, flush = 0, set_flags = 0;
  logic [47:0] alu_out = 0, store_data = 0;
  logic [3:0] rd = 0, nzvc = 0;
  logic reg_write = 0, mem_read = 0, mem_write = 0;
  logic in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [47:0] out_result, out_store_data;
  logic [3:0] out_rd, flags;
  int n_tests = 0, n_fail = 0;

  typedef struct packed {
    logic [47:0] r;
    logic [47:0] s;
    logic [3:0]  d;
    logic [2:0]  c;
  } ent_t;
  ent_t mq[$];
  logic [3:0] mflags = 0;

  always #5 clk = ~clk;

  execute_mem_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_n(nzvc[3]), .alu_z(nzvc[2]), .alu_v(nzvc[1]), .alu_c(nzvc[0]),
    .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .set_flags(set_flags), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .flags(flags)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a 2-deep FIFO; accepts when it holds fewer than two entries.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mflags = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic logic acc = in_valid && mq.size() < 2;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({alu_out, store_data, rd, reg_write, mem_read, mem_write});
        if (set_flags) mflags = nzvc;
      end
    end
  end

  always @(negedge clk) begin
    automatic ent_t e = mq.size() > 0 ? mq[0] : '0;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("payload", {out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write}, e);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("flags", flags, mflags);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [47:0] r, input logic [3:0] d,
                     input logic [2:0] c, input logic [3:0] f, input logic sf);
    in_valid = v;
    alu_out = r;
    store_data = ~r;
    rd = d;
    {reg_write, mem_read, mem_write} = c;
    nzvc = f;
    set_flags = sf;
  endtask

  initial begin
    logic [23:0] pv, pr;
    pv = 24'b1101_1110_1011_0111_1100_1111;
    pr = 24'b0110_0011_1101_0100_1111_1001;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", {out_result, out_store_data, out_rd, out_reg_write}, 0);
    // pass-through
    out_ready = 1;
    put(1, 48'h5, 4'd3, 3'b100, 4'b0000, 0);
    step();
    chk("pt_valid", out_valid, 1);
    chk("pt_result", out_result, 48'h5);
    chk("pt_rd", out_rd, 4'd3);
    chk("pt_rw", out_reg_write, 1);
    put(0, 0, 0, 0, 0, 0);
    step();
    chk("pt_empty", out_valid, 0);
    // backpressure: A to main, B to skid, C refused
    out_ready = 0;
    put(1, 48'hA, 4'd1, 3'b010, 4'b0000, 0);
    step();
    put(1, 48'hB, 4'd2, 3'b001, 4'b0000, 0);
    step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_main_a", out_result, 48'hA);
    put(1, 48'hC, 4'd4, 3'b100, 4'b0000, 0);
    step();
    chk("bp_hold_a", out_result, 48'hA);
    chk("bp_hold_rd", out_rd, 4'd1);
    out_ready = 1;
    step();
    chk("bp_out_b", out_result, 48'hB);
    step();
    chk("bp_out_c", out_result, 48'hC);
    put(0, 0, 0, 0, 0, 0);
    step();
    chk("bp_drained", out_valid, 0);
    // flags
    put(1, 48'h11, 4'd5, 3'b100, 4'b0101, 1);
    step();
    chk("flags_set", flags, 4'b0101);
    put(1, 48'h12, 4'd6, 3'b100, 4'b1000, 0);
    step();
    chk("flags_hold", flags, 4'b0101);
    // flush with both entries full
    out_ready = 0;
    put(1, 48'hD, 4'd7, 3'b100, 4'b0000, 0);
    step();
    put(1, 48'hE, 4'd8, 3'b010, 4'b0000, 0);
    step();
    flush = 1;
    put(1, 48'hF, 4'd9, 3'b100, 4'b1010, 1);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_flags", flags, 4'b0101);
    step();
    chk("fl_drop_flags", flags, 4'b0101);
    flush = 0;
    out_ready = 1;
    put(0, 0, 0, 0, 0, 0);
    step();
    chk("fl_no_ghost", out_valid, 0);
    // directed in_valid/out_ready mix, throughput and ordering via the model
    for (int i = 0; i < 24; i++) begin
      put(pv[i], 48'h100 + 48'(i), 4'(i), 3'(i), 4'(i), i[0]);
      out_ready = pr[i];
      step();
    end
    // async reset mid-stall
    out_ready = 0;
    put(1, 48'h21, 4'd1, 3'b100, 4'b1111, 1);
    step();
    put(1, 48'h22, 4'd2, 3'b100, 4'b0000, 0);
    step();
    put(0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_flags", flags, 4'b0000);
    chk("ar_in_ready", in_ready, 1);
    #2 rst = 0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
